// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC-like CPU: opcodes, sequencer states,
// instruction field positions and small decode helpers.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_MOV = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_WB     = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS0_MSB = 7;
    localparam int RS0_LSB = 4;
    localparam int RS1_MSB = 3;
    localparam int RS1_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Ops 1..9 produce a register result and update the zero flag.
    function automatic logic op_writes(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MOV);
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction-memory and register-file bus between the sequencer (master)
// and the memory/register-file side (slave).
interface control_unit_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic            rf_we;
    logic [3:0]      rf_src0;
    logic [3:0]      rf_src1;
    logic [3:0]      rf_dst;
    logic [7:0]      rf_wdata;
    logic [7:0]      rf_data0;
    logic [7:0]      rf_data1;

    modport master (
        output imem_addr, rf_we, rf_src0, rf_src1, rf_dst, rf_wdata,
        input  imem_data, rf_data0, rf_data1
    );

    modport slave (
        input  imem_addr, rf_we, rf_src0, rf_src1, rf_dst, rf_wdata,
        output imem_data, rf_data0, rf_data1
    );
endinterface

// File: rtl/control_unit_alu.sv
// Combinational 8-bit ALU; LDI is not handled here because it needs the
// immediate, which the sequencer selects itself.
module alu
    import cpu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op,
    output logic [7:0] y
);

    // Result selection; every non-ALU opcode yields zero.
    always_comb begin
        y = 8'h00;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SHL:  y = {a[6:0], 1'b0};
            OP_SHR:  y = {1'b0, a[7:1]};
            OP_MOV:  y = a;
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Four-cycle fetch/decode/execute/writeback sequencer with program counter,
// zero flag, branch and halt control for the 8-bit CPU.
module control_unit
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    control_unit_if.master  bus,
    output logic [PC_W-1:0] pc,
    output logic            zero,
    output logic            halted
);

    logic [2:0]      state_r;
    logic [2:0]      state_next_s;
    logic [15:0]     ir_r;
    logic [PC_W-1:0] pc_r;
    logic [7:0]      result_r;
    logic            zero_r;
    logic            taken_r;
    logic            rf_we_r;
    logic            halted_r;

    logic [3:0]      op_s;
    logic [3:0]      rd_s;
    logic [3:0]      rs0_s;
    logic [3:0]      rs1_s;
    logic [7:0]      imm_s;
    logic [7:0]      alu_y_s;
    logic [7:0]      result_next_s;
    logic            taken_next_s;

    assign op_s  = ir_r[OP_MSB:OP_LSB];
    assign rd_s  = ir_r[RD_MSB:RD_LSB];
    assign rs0_s = ir_r[RS0_MSB:RS0_LSB];
    assign rs1_s = ir_r[RS1_MSB:RS1_LSB];
    assign imm_s = ir_r[IMM_MSB:IMM_LSB];

    alu u_alu (
        .a  (bus.rf_data0),
        .b  (bus.rf_data1),
        .op (op_s),
        .y  (alu_y_s)
    );

    // JZ tests reg[rd], so read port 0 is steered to rd for that opcode.
    always_comb begin
        if (op_s == OP_JZ) begin
            bus.rf_src0 = rd_s;
        end else begin
            bus.rf_src0 = rs0_s;
        end
    end

    assign bus.rf_src1   = rs1_s;
    assign bus.rf_dst    = rd_s;
    assign bus.rf_wdata  = result_r;
    assign bus.rf_we     = rf_we_r;
    assign bus.imem_addr = pc_r;
    assign pc            = pc_r;
    assign zero          = zero_r;
    assign halted        = halted_r;

    // Execute-stage result and branch decision.
    always_comb begin
        if (op_s == OP_LDI) begin
            result_next_s = imm_s;
        end else begin
            result_next_s = alu_y_s;
        end
        case (op_s)
            OP_JMP:  taken_next_s = 1'b1;
            OP_JZ:   taken_next_s = (bus.rf_data0 == 8'h00);
            default: taken_next_s = 1'b0;
        endcase
    end

    // Sequencer next state; HALT is left only through reset.
    always_comb begin
        state_next_s = ST_FETCH;
        case (state_r)
            ST_FETCH:  state_next_s = ST_DECODE;
            ST_DECODE: state_next_s = ST_EXEC;
            ST_EXEC:   state_next_s = ST_WB;
            ST_WB: begin
                if (op_s == OP_HLT) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_HALT:   state_next_s = ST_HALT;
            default:   state_next_s = ST_FETCH;
        endcase
    end

    // Architectural state; rf_we/halted are registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_FETCH;
            ir_r     <= 16'h0000;
            pc_r     <= {PC_W{1'b0}};
            result_r <= 8'h00;
            zero_r   <= 1'b0;
            taken_r  <= 1'b0;
            rf_we_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            rf_we_r  <= (state_next_s == ST_WB) && op_writes(op_s);
            halted_r <= (state_next_s == ST_HALT);
            case (state_r)
                ST_FETCH: ir_r <= bus.imem_data;
                ST_EXEC: begin
                    result_r <= result_next_s;
                    taken_r  <= taken_next_s;
                    if (op_writes(op_s)) begin
                        zero_r <= (result_next_s == 8'h00);
                    end
                end
                ST_WB: begin
                    if (op_s != OP_HLT) begin
                        if (taken_r) begin
                            pc_r <= PC_W'(imm_s);
                        end else begin
                            pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed plus randomized program run against an instruction-level model of
// the CPU kept in the bench; the bench also plays instruction memory and RF.
module tb_control_unit;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] pc;
    logic       zero;
    logic       halted;

    control_unit_if #(.PC_W(8)) bus ();

    control_unit #(.PC_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .pc     (pc),
        .zero   (zero),
        .halted (halted)
    );

    always #5 clk = ~clk;

    logic [15:0] imem [256];
    logic [7:0]  rf   [16];

    assign bus.imem_data = imem[bus.imem_addr];
    assign bus.rf_data0  = rf[bus.rf_src0];
    assign bus.rf_data1  = rf[bus.rf_src1];

    always @(posedge clk) begin
        if (bus.rf_we) rf[bus.rf_dst] <= bus.rf_wdata;
    end

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_reg [16];
    logic [7:0] m_pc;
    logic       m_zero;
    logic       m_halted;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from its FETCH cycle (called at a negedge) and
    // checks every cycle against the instruction-level model.
    task automatic run_instr(input logic [15:0] w);
        logic [3:0] op, rd, rs0, rs1;
        logic [7:0] a, b, imm, npc;
        int v;
        logic wr;
        op  = w[15:12];
        rd  = w[11:8];
        rs0 = w[7:4];
        rs1 = w[3:0];
        imm = w[7:0];
        imem[m_pc] = w;
        a  = m_reg[rs0];
        b  = m_reg[rs1];
        wr = 1'b1;
        v  = 0;
        case (op)
            4'h1: v = (a + b) % 256;
            4'h2: v = (int'(a) + 256 - int'(b)) % 256;
            4'h3: v = int'(a & b);
            4'h4: v = int'(a | b);
            4'h5: v = int'(a ^ b);
            4'h6: v = (int'(a) * 2) % 256;
            4'h7: v = int'(a) / 2;
            4'h8: v = int'(imm);
            4'h9: v = int'(a);
            default: wr = 1'b0;
        endcase
        case (op)
            4'hA: npc = imm;
            4'hB: npc = (m_reg[rd] == 8'h00) ? imm : m_pc + 8'd1;
            4'hF: npc = m_pc;
            default: npc = m_pc + 8'd1;
        endcase
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                check("rf_we_wb", {15'd0, bus.rf_we}, {15'd0, wr});
                if (wr) begin
                    check("rf_dst", {12'd0, bus.rf_dst}, {12'd0, rd});
                    check("rf_wdata", {8'd0, bus.rf_wdata}, 16'(v));
                end
            end else begin
                check("rf_we_idle", {15'd0, bus.rf_we}, 16'd0);
            end
            check("pc_stable", {8'd0, pc}, {8'd0, m_pc});
            check("halted_run", {15'd0, halted}, 16'd0);
            @(posedge clk);
            @(negedge clk);
        end
        if (wr) begin
            m_reg[rd] = v[7:0];
            m_zero    = (v == 0);
        end
        m_pc = npc;
        if (op == 4'hF) m_halted = 1'b1;
        check("pc_next", {8'd0, pc}, {8'd0, m_pc});
        check("zero", {15'd0, zero}, {15'd0, m_zero});
        check("halted", {15'd0, halted}, {15'd0, m_halted});
    endtask

    initial begin
        logic [15:0] w;
        rst_n    = 1'b0;
        m_pc     = 8'h00;
        m_zero   = 1'b0;
        m_halted = 1'b0;
        imem[0]  = 16'h1312;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pc", {8'd0, pc}, 16'd0);
        check("rst_we", {15'd0, bus.rf_we}, 16'd0);
        check("rst_zero", {15'd0, zero}, 16'd0);
        check("rst_halted", {15'd0, halted}, 16'd0);
        rst_n = 1'b1;

        // Abort an ADD in its EXEC cycle with a three-cycle reset.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_we", {15'd0, bus.rf_we}, 16'd0);
            check("abort_pc", {8'd0, pc}, 16'd0);
            check("abort_halted", {15'd0, halted}, 16'd0);
        end
        rst_n = 1'b1;

        run_instr(16'h8105);
        run_instr(16'h8203);
        run_instr(16'h1312);
        check("pc_after_3", {8'd0, pc}, 16'h0003);
        run_instr(16'h2421);
        run_instr(16'h5511);
        run_instr(16'hB520);
        check("jz_taken", {8'd0, pc}, 16'h0020);
        run_instr(16'hB140);
        check("jz_not_taken", {8'd0, pc}, 16'h0021);
        run_instr(16'hA010);
        run_instr(16'hD123);
        check("reserved_nop", {8'd0, pc}, 16'h0011);
        run_instr(16'hA0FF);
        run_instr(16'h0000);
        check("pc_wrap", {8'd0, pc}, 16'h0000);
        run_instr(16'hA007);
        run_instr(16'hF000);

        repeat (20) begin
            check("halt_we", {15'd0, bus.rf_we}, 16'd0);
            check("halt_pc", {8'd0, pc}, 16'h0007);
            check("halt_flag", {15'd0, halted}, 16'd1);
            @(posedge clk);
            @(negedge clk);
        end

        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        m_pc     = 8'h00;
        m_zero   = 1'b0;
        m_halted = 1'b0;
        check("rearm_pc", {8'd0, pc}, 16'd0);
        check("rearm_halted", {15'd0, halted}, 16'd0);
        check("rearm_zero", {15'd0, zero}, 16'd0);

        for (int r = 0; r < 16; r++) begin
            w = {4'h8, 4'(r), 8'($urandom_range(0, 255))};
            if (r % 5 == 0) w[7:0] = 8'h00;
            run_instr(w);
        end

        for (int i = 0; i < 150; i++) begin
            w = 16'($urandom_range(0, 65535));
            if (w[15:12] == 4'hF) w[15:12] = 4'hB;
            run_instr(w);
        end

        run_instr(16'hF000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
